// File: rtl/rced_pkg.sv
// Shared types and helpers for the stochastic-computing Roberts-cross edge detector.
// Holds the FSM state enum, the LFSR tap table and the length-exponent width helper.
package rced_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // Maximal-length Fibonacci tap masks, with bit k standing for register stage k.
    function automatic logic [15:0] lfsr_taps(input int width);
        case (width)
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic int len_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sc_lfsr_dbj.sv
// WIDTH-bit de Bruijn LFSR: a maximal Fibonacci LFSR with the all-zero state spliced in,
// so the sequence covers all 2^WIDTH values. Load has priority over enable.
module sc_lfsr_dbj
    import rced_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SEED  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] state_o
);

    localparam logic [15:0]      TAPS_ALL = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic             fb;

    always_comb begin
        // NOTE: every always_comb output is defaulted first so no latch can be inferred.
        state_d = state_q;
        // Inverting feedback when the low stages are all zero inserts 0 after 100..0.
        fb = (^(state_q & TAPS)) ^ (state_q[WIDTH-2:0] == '0);
        if (load_i) begin
            state_d = WIDTH'(SEED);
        end else if (en_i) begin
            state_d = {state_q[WIDTH-2:0], fb};
        end
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WIDTH'(SEED);
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/rced_sc_et.sv
// Sequential stochastic Roberts-cross edge detector with a runtime-selected stream length.
// Four pixels share one de Bruijn LFSR so that XOR of correlated streams yields |a-b|.
module rced_sc_et
    import rced_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int SEED  = 1,
    localparam int LW    = len_w(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    output logic                  ready_o,
    input  logic [3:0][WIDTH-1:0] bx_i,
    input  logic [LW-1:0]         log_len_i,
    output logic                  busy_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [WIDTH-1:0]      bz_o
);

    state_t                state_q;
    logic [3:0][WIDTH-1:0] bx_q;
    logic [LW-1:0]         log_len_q;
    logic [WIDTH-1:0]      cyc_q;
    logic [WIDTH:0]        cnt_q;
    logic [WIDTH-1:0]      bz_q;
    logic                  ready_q;
    logic                  busy_q;
    logic                  valid_q;

    logic [WIDTH-1:0]      r;
    logic [LW-1:0]         len_sel;
    logic [3:0]            x;
    logic                  z;
    logic                  last;
    logic [WIDTH:0]        cnt_d;
    logic [WIDTH:0]        last_idx;
    logic [WIDTH:0]        scaled;
    logic [WIDTH-1:0]      bz_d;

    sc_lfsr_dbj #(
        .WIDTH(WIDTH),
        .SEED (SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load_i (state_q == ST_IDLE && start_i),
        .en_i   (state_q == ST_RUN),
        .state_o(r)
    );

    always_comb begin
        len_sel = log_len_i;
        if (log_len_i == '0 || log_len_i > LW'(WIDTH)) begin
            len_sel = LW'(WIDTH);
        end
        for (int i = 0; i < 4; i++) begin
            x[i] = r < bx_q[i];
        end
        z        = cyc_q[0] ? (x[0] ^ x[3]) : (x[1] ^ x[2]);
        cnt_d    = cnt_q + (WIDTH+1)'(z);
        last_idx = ((WIDTH+1)'(1) << log_len_q) - (WIDTH+1)'(1);
        last     = ({1'b0, cyc_q} == last_idx);
        // Rescale to full range; only a count of exactly L reaches bit WIDTH.
        scaled   = cnt_d << (LW'(WIDTH) - log_len_q);
        bz_d     = scaled[WIDTH] ? '1 : scaled[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bx_q      <= '0;
            log_len_q <= LW'(WIDTH);
            cyc_q     <= '0;
            cnt_q     <= '0;
            bz_q      <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        bx_q      <= bx_i;
                        log_len_q <= len_sel;
                        cyc_q     <= '0;
                        cnt_q     <= '0;
                        state_q   <= ST_RUN;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    cnt_q <= cnt_d;
                    cyc_q <= cyc_q + WIDTH'(1);
                    if (last) begin
                        bz_q    <= bz_d;
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (ready_i) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o = ready_q;
    assign busy_o  = busy_q;
    assign valid_o = valid_q;
    assign bz_o    = bz_q;

endmodule

// File: tb/tb_rced_sc_et.sv
// Randomised self-checking bench for rced_sc_et against a stream-level reference model.
// Latency is counted with the accepting clock edge as cycle 1.
module tb_rced_sc_et;

    localparam int WIDTH = 8;
    localparam int SEED  = 1;
    localparam int LW    = $clog2(WIDTH + 1);

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start_i;
    logic                  ready_o;
    logic [3:0][WIDTH-1:0] bx_i;
    logic [LW-1:0]         log_len_i;
    logic                  busy_o;
    logic                  valid_o;
    logic                  ready_i;
    logic [WIDTH-1:0]      bz_o;

    int total = 0;
    int bad   = 0;
    int seq[256];

    rced_sc_et #(
        .WIDTH(WIDTH),
        .SEED (SEED)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .ready_o  (ready_o),
        .bx_i     (bx_i),
        .log_len_i(log_len_i),
        .busy_o   (busy_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .bz_o     (bz_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Plain maximal LFSR for x^8+x^6+x^5+x^4+1; the zero state is spliced in separately.
    function automatic logic [7:0] plain_next(input logic [7:0] s);
        return {s[6:0], ^(s & 8'hB8)};
    endfunction

    function automatic int clamp_len(input int ll);
        return (ll == 0 || ll > WIDTH) ? WIDTH : ll;
    endfunction

    // Count the Roberts-cross output stream over L random levels, then rescale and saturate.
    function automatic int model_bz(input logic [3:0][7:0] b, input int ll_raw);
        int ll;
        int cnt;
        int scaled;
        ll  = clamp_len(ll_raw);
        cnt = 0;
        for (int k = 0; k < (1 << ll); k++) begin
            if (k % 2 == 1) cnt += int'((seq[k] < b[0]) != (seq[k] < b[3]));
            else            cnt += int'((seq[k] < b[1]) != (seq[k] < b[2]));
        end
        scaled = cnt << (WIDTH - ll);
        return (scaled > 255) ? 255 : scaled;
    endfunction

    // Called just after the accepting edge; waits for the result with a bounded budget.
    task automatic finish_run(input logic [3:0][7:0] b, input int ll_raw, input string tag);
        int n;
        int len;
        len = 1 << clamp_len(ll_raw);
        n   = 1;
        check({tag, "/busy"}, busy_o, 1);
        check({tag, "/notready"}, ready_o, 0);
        while (!valid_o && n < 400) begin
            step();
            n++;
        end
        check({tag, "/latency"}, n, len + 1);
        check({tag, "/bz"}, bz_o, model_bz(b, ll_raw));
    endtask

    task automatic start_run(input logic [3:0][7:0] b, input int ll_raw, input string tag);
        check({tag, "/idle"}, ready_o, 1);
        bx_i      = b;
        log_len_i = LW'(ll_raw);
        start_i   = 1'b1;
        step();
        start_i   = 1'b0;
        bx_i      = $urandom;
        log_len_i = LW'($urandom);
        finish_run(b, ll_raw, tag);
    endtask

    task automatic release_result(input int hold, input int exp_bz, input bit poke, input string tag);
        for (int h = 0; h < hold; h++) begin
            ready_i = 1'b0;
            if (poke) start_i = 1'($urandom_range(0, 1));
            step();
            check({tag, "/holdvalid"}, valid_o, 1);
            check({tag, "/holdbz"}, bz_o, exp_bz);
        end
        start_i = 1'b0;
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        check({tag, "/dropvalid"}, valid_o, 0);
        check({tag, "/backready"}, ready_o, 1);
    endtask

    task automatic run_and_release(input logic [3:0][7:0] b, input int ll_raw, input int hold,
                                   input string tag);
        start_run(b, ll_raw, tag);
        release_result(hold, model_bz(b, ll_raw), 1'b1, tag);
    endtask

    initial begin
        logic [7:0]            s;
        logic [3:0][WIDTH-1:0] b;
        logic [3:0][WIDTH-1:0] b2;
        int                    ll;
        int                    pick;
        int                    vcount;
        int                    exp1;

        rst       = 1'b1;
        start_i   = 1'b0;
        ready_i   = 1'b0;
        bx_i      = '0;
        log_len_i = '0;

        s = 8'(SEED);
        for (int k = 0; k < 256; k++) begin
            seq[k] = int'(s);
            if (s == 8'h00)      s = 8'h01;
            else if (s == 8'h80) s = 8'h00;
            else                 s = plain_next(s);
        end

        // Reset is asynchronous: outputs must be at reset values before any clock edge.
        #2;
        check("reset/ready", ready_o, 1);
        check("reset/busy", busy_o, 0);
        check("reset/valid", valid_o, 0);
        check("reset/bz", bz_o, 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        step();

        // Reset in the middle of a run discards it with no valid pulse.
        bx_i      = {8'd10, 8'd200, 8'd90, 8'd30};
        log_len_i = LW'(8);
        start_i   = 1'b1;
        step();
        start_i = 1'b0;
        repeat (5) step();
        #2 rst = 1'b1;
        #1;
        check("midrst/ready", ready_o, 1);
        check("midrst/busy", busy_o, 0);
        check("midrst/valid", valid_o, 0);
        check("midrst/bz", bz_o, 0);
        step();
        #2 rst = 1'b0;
        vcount = 0;
        for (int c = 0; c < 300; c++) begin
            step();
            if (valid_o) vcount++;
        end
        check("midrst/novalid", vcount, 0);

        run_and_release('0, 8, 0, "zero");
        for (int l = 1; l <= 8; l++) begin
            run_and_release({4{8'd200}}, l, 0, $sformatf("equal%0d", l));
        end
        run_and_release({8'd0, 8'd255, 8'd0, 8'd0}, 8, 1, "edge8");
        run_and_release({8'd0, 8'd255, 8'd0, 8'd0}, 4, 1, "edge4");
        run_and_release({8'd7, 8'd99, 8'd180, 8'd250}, 0, 0, "clamp0");
        run_and_release({8'd250, 8'd3, 8'd64, 8'd128}, 12, 0, "clamp12");

        // Backpressure with ignored start pulses, then a back-to-back start.
        b = {8'd12, 8'd240, 8'd77, 8'd150};
        start_run(b, 2, "hs");
        exp1 = model_bz(b, 2);
        for (int h = 0; h < 10; h++) begin
            ready_i = 1'b0;
            start_i = 1'(h % 2);
            step();
            check("hs/valid", valid_o, 1);
            check("hs/busy", busy_o, 0);
            check("hs/bz", bz_o, exp1);
        end
        b2        = {8'd5, 8'd180, 8'd220, 8'd40};
        bx_i      = b2;
        log_len_i = LW'(3);
        start_i   = 1'b1;
        ready_i   = 1'b1;
        step();
        ready_i = 1'b0;
        check("b2b/gapvalid", valid_o, 0);
        check("b2b/gapready", ready_o, 1);
        check("b2b/gapbusy", busy_o, 0);
        step();
        start_i   = 1'b0;
        bx_i      = $urandom;
        log_len_i = LW'($urandom);
        finish_run(b2, 3, "b2b");
        release_result(0, model_bz(b2, 3), 1'b0, "b2b");

        for (int i = 0; i < 1000; i++) begin
            pick = $urandom_range(0, 99);
            if (pick < 2)      ll = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(9, 15);
            else if (pick < 5) ll = $urandom_range(6, 8);
            else               ll = $urandom_range(1, 5);
            b = $urandom;
            if ($urandom_range(0, 9) == 0) b = {4{b[0]}};
            run_and_release(b, ll, $urandom_range(0, 3), $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rced_sc_et.md
Name: rced_sc_et

Overview:
- Parametrised, fully sequential stochastic-computing Roberts-cross edge detector with programmable early termination.
- Accepts four binary pixel values and converts them to correlated bitstreams via one shared de Bruijn-extended LFSR.
- Evaluates the XOR/mux Roberts-cross kernel each cycle and accumulates the output stream in an up-counter.
- After a runtime-selected stream length of 2^log_len cycles, returns a WIDTH-bit binary edge magnitude over a valid/ready handshake.

Parameters:
- WIDTH, 8, pixel/result bit width and LFSR width; legal 4..16.
- SEED, 1, LFSR load value at every accepted start; must be nonzero and < 2^WIDTH.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  request to begin a conversion; accepted only when ready_o=1
- ready_o  out  1  high in IDLE only
- bx_i  in  4xWIDTH  pixels x[0..3], sampled on the accepted-start edge
- log_len_i  in  $clog2(WIDTH+1)  stream length exponent, sampled with bx_i; legal 1..WIDTH
- busy_o  out  1  high in RUN
- valid_o  out  1  result valid, high in DONE
- ready_i  in  1  consumer accepts result when valid_o & ready_i
- bz_o  out  WIDTH  result, stable while valid_o=1

Behaviour:
- Reset (asynchronous): state=IDLE, ready_o=1, busy_o=0, valid_o=0, bz_o=0, counters=0, LFSR=SEED.
- FSM IDLE: on start_i, latch bx_i and log_len_i, load LFSR=SEED, clear cnt and cyc, go to RUN.
  - Illegal log_len (0 or >WIDTH) is clamped to WIDTH.
- FSM RUN: one stream bit per cycle for exactly L=2^log_len cycles, indexed cyc=0..L-1.
  - r = current de Bruijn LFSR state. It visits all 2^WIDTH values, including 0, once per period.
  - Stream bit x_i = (r < bx_i).
  - Select c = cyc[0], so c=0 on cycle 0.
  - z = c ? (x0 ^ x3) : (x1 ^ x2).
  - cnt += z. cnt is WIDTH+1 bits.
  - LFSR advances every RUN cycle.
  - On cyc==L-1, the final bit is included and the FSM goes to DONE.
  - bz_o is registered on that same edge.
- Result: bz_o = min(cnt << (WIDTH-log_len), 2^WIDTH-1), saturating when cnt==L.
- Latency: valid_o rises exactly L+1 clocks after the accepted start edge.
- FSM DONE: valid_o=1, bz_o held.
  - On valid_o & ready_i, go to IDLE. valid_o drops and ready_o rises on the next edge.
  - start_i is ignored in DONE and RUN; there is no queueing.
- Back-to-back operation: start_i held high gives a new conversion one cycle after handshake completion. The IDLE cycle is mandatory.
- Input stability: bx_i and log_len_i may change freely after the accepted start edge, because the latched copies are used.
- Reset mid-RUN or mid-DONE: immediate return to the reset values; the partial result is discarded and no valid_o pulse occurs.
- Correlation: all four x streams share r, which is required for XOR to compute |a-b|.

Decomposition:
- Shared package rced_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the function lfsr_taps(WIDTH) returning the maximal-length Fibonacci tap mask for widths 4..16;
  - the length-exponent width helper.
- One sub-module, sc_lfsr_dbj: a WIDTH-bit de Bruijn LFSR with load (seed) and enable, output = state.
- The Roberts-cross kernel and the counter stay inline.

Test Plan:
- Reset then idle: rst pulsed mid-RUN at cycle 5 -> outputs return to ready_o=1, busy_o=0, valid_o=0, bz_o=0 asynchronously; no valid_o ever follows.
- WIDTH=8, bx=(0,0,0,0), log_len=8 -> valid_o at cycle 257 after start, bz_o=0.
- Equal pixels bx=(200,200,200,200) -> every x stream is identical and z is always 0, so bz_o=0 for every log_len 1..8.
- bx=(0,0,255,0), log_len=8 -> cnt=127 or 128 per golden model (127 iff r==255 on an even cyc); bz_o equals cnt.
  - Repeat with log_len=4 -> bz_o = cnt<<4 and matches the golden model; valid_o at cycle 17.
- Handshake: hold ready_i=0 for 10 cycles after valid_o -> bz_o is stable and start_i pulses are ignored.
  - Then ready_i=1 with start_i held -> the next run starts after exactly one IDLE cycle.
- Random regression: 1000 random bx/log_len tuples with random ready_i backpressure -> bz_o and valid_o timing match a cycle-accurate reference model using SEED reload.
